// File: rtl/mem_arbiter.sv
// Byte-wide external memory port arbiter: serialises instruction fetches and
// load/store buffer accesses onto RAM/IO one byte per cycle, little-endian.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [1:0]  IO_SEL     = 2'b11
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  rob_clear,
    input  logic                  if_valid,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ready,
    output logic [31:0]           if_data,
    input  logic                  ls_valid,
    input  logic                  ls_wr,
    input  logic [1:0]            ls_size,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [31:0]           ls_wdata,
    output logic                  ls_ready,
    output logic [31:0]           ls_rdata,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);

    typedef enum logic [1:0] {StIdle, StFetch, StLoad, StStore} state_e;

    localparam logic [ADDR_WIDTH-1:0] AddrOne = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [2:0]            len_q, len_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           data_q, data_d;
    logic                  last_ls_q, last_ls_d;
    logic                  if_ready_q, if_ready_d;
    logic                  ls_ready_q, ls_ready_d;
    logic [31:0]           if_data_q, if_data_d;
    logic [31:0]           ls_rdata_q, ls_rdata_d;
    logic [7:0]            mem_dout_q, mem_dout_d;
    logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
    logic                  mem_wr_q, mem_wr_d;

    logic       if_elig, ls_elig, can_grant, pick_ls;
    logic [2:0] ls_len, byte_idx;

    always_comb begin
        if_elig   = if_valid & ~rob_clear;
        ls_elig   = ls_valid & (ls_wr ? ~((ls_addr[17:16] == IO_SEL) & io_buffer_full)
                                      : ~rob_clear);
        // The done cycle is a bubble so a requester can drop valid before regrant.
        can_grant = (state_q == StIdle) & rdy_in & ~if_ready_q & ~ls_ready_q;
        pick_ls   = ls_elig & (~if_elig | ~last_ls_q);
        unique case (ls_size)
            2'd0:    ls_len = 3'd1;
            2'd1:    ls_len = 3'd2;
            default: ls_len = 3'd4;
        endcase
        byte_idx  = cnt_q - 3'd2;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        wdata_d    = wdata_q;
        data_d     = data_q;
        last_ls_d  = last_ls_q;
        if_ready_d = 1'b0;
        ls_ready_d = 1'b0;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        mem_dout_d = mem_dout_q;
        mem_a_d    = mem_a_q;
        mem_wr_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (can_grant && (if_elig || ls_elig)) begin
                    cnt_d  = 3'd1;
                    data_d = 32'd0;
                    if (pick_ls) begin
                        last_ls_d = 1'b1;
                        len_d     = ls_len;
                        mem_a_d   = ls_addr;
                        if (ls_wr) begin
                            state_d    = StStore;
                            wdata_d    = ls_wdata;
                            mem_wr_d   = 1'b1;
                            mem_dout_d = ls_wdata[7:0];
                        end else begin
                            state_d = StLoad;
                        end
                    end else begin
                        last_ls_d = 1'b0;
                        len_d     = 3'd4;
                        mem_a_d   = if_addr;
                        state_d   = StFetch;
                    end
                end
            end
            StFetch, StLoad: begin
                if (rob_clear) begin
                    state_d = StIdle;
                end else begin
                    if (cnt_q < len_q) begin
                        mem_a_d = mem_a_q + AddrOne;
                    end
                    // RAM returns each byte two edges after its address was issued.
                    if (cnt_q >= 3'd2) begin
                        data_d[{byte_idx[1:0], 3'b000} +: 8] = mem_din;
                    end
                    if (cnt_q == len_q + 3'd1) begin
                        state_d = StIdle;
                        if (state_q == StFetch) begin
                            if_ready_d = 1'b1;
                            if_data_d  = data_d;
                        end else begin
                            ls_ready_d = 1'b1;
                            ls_rdata_d = data_d;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            StStore: begin
                if (cnt_q == len_q) begin
                    state_d    = StIdle;
                    ls_ready_d = 1'b1;
                end else begin
                    mem_wr_d   = 1'b1;
                    mem_a_d    = mem_a_q + AddrOne;
                    mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                    cnt_d      = cnt_q + 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= StIdle;
            cnt_q      <= 3'd0;
            len_q      <= 3'd0;
            wdata_q    <= 32'd0;
            data_q     <= 32'd0;
            last_ls_q  <= 1'b0;
            if_ready_q <= 1'b0;
            ls_ready_q <= 1'b0;
            if_data_q  <= 32'd0;
            ls_rdata_q <= 32'd0;
            mem_dout_q <= 8'd0;
            mem_a_q    <= '0;
            mem_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            wdata_q    <= wdata_d;
            data_q     <= data_d;
            last_ls_q  <= last_ls_d;
            if_ready_q <= if_ready_d;
            ls_ready_q <= ls_ready_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
            mem_dout_q <= mem_dout_d;
            mem_a_q    <= mem_a_d;
            mem_wr_q   <= mem_wr_d;
        end
    end

    assign if_ready = if_ready_q;
    assign if_data  = if_data_q;
    assign ls_ready = ls_ready_q;
    assign ls_rdata = ls_rdata_q;
    assign mem_dout = mem_dout_q;
    assign mem_a    = mem_a_q;
    assign mem_wr   = mem_wr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: RAM model plus response/write scoreboards.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          rdy_in = 1'b1;
    logic          rob_clear = 1'b0;
    logic          if_valid = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ready;
    logic [31:0]   if_data;
    logic          ls_valid = 1'b0;
    logic          ls_wr = 1'b0;
    logic [1:0]    ls_size = 2'd0;
    logic [AW-1:0] ls_addr = '0;
    logic [31:0]   ls_wdata = '0;
    logic          ls_ready;
    logic [31:0]   ls_rdata;
    logic [7:0]    mem_din;
    logic [7:0]    mem_dout;
    logic [AW-1:0] mem_a;
    logic          mem_wr;
    logic          io_buffer_full = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct {logic chk; logic [31:0] data;} resp_t;
    typedef struct {logic [31:0] a; logic [7:0] d;} wr_t;
    resp_t if_q[$];
    resp_t ls_q[$];
    wr_t   wr_q[$];

    logic [7:0]  ram [0:4095];
    logic [11:0] ram_a = 12'd0;

    mem_arbiter #(.ADDR_WIDTH(AW), .IO_SEL(2'b11)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
        .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
        .ls_valid(ls_valid), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_ready(ls_ready), .ls_rdata(ls_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    // RAM registers the address at edge k and drives that byte until edge k+2.
    always @(posedge clk_in) begin
        if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
        ram_a <= mem_a[11:0];
    end
    assign mem_din = ram[ram_a];

    // Scoreboard consumer: every done pulse and every RAM write must be expected.
    always @(negedge clk_in) begin
        resp_t r;
        wr_t   w;
        if (if_ready) begin
            total++;
            if (if_q.size() == 0) begin
                bad++;
                $display("FAIL if_resp: unexpected if_ready, data=%h", if_data);
            end else begin
                r = if_q.pop_front();
                if (if_data !== r.data) begin
                    bad++;
                    $display("FAIL if_data: got %h expected %h", if_data, r.data);
                end
            end
        end
        if (ls_ready) begin
            total++;
            if (ls_q.size() == 0) begin
                bad++;
                $display("FAIL ls_resp: unexpected ls_ready, data=%h", ls_rdata);
            end else begin
                r = ls_q.pop_front();
                if (r.chk && ls_rdata !== r.data) begin
                    bad++;
                    $display("FAIL ls_rdata: got %h expected %h", ls_rdata, r.data);
                end
            end
        end
        if (mem_wr) begin
            total++;
            if (wr_q.size() == 0) begin
                bad++;
                $display("FAIL mem_write: unexpected write a=%h d=%h", mem_a, mem_dout);
            end else begin
                w = wr_q.pop_front();
                if (mem_a !== w.a || mem_dout !== w.d) begin
                    bad++;
                    $display("FAIL mem_write: got a=%h d=%h expected a=%h d=%h",
                             mem_a, mem_dout, w.a, w.d);
                end
            end
        end
    end

    task automatic do_reset();
        rst_in = 1'b0; if_valid = 1'b0; ls_valid = 1'b0; rob_clear = 1'b0;
        io_buffer_full = 1'b0; rdy_in = 1'b1; ls_wr = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic test_reset();
        #2 rst_in = 1'b0;
        #1;
        total++;
        if ({if_ready, ls_ready, mem_wr} !== 3'b000) begin
            bad++; $display("FAIL reset_ctrl: got %b expected 000", {if_ready, ls_ready, mem_wr});
        end
        total++;
        if (mem_a !== '0 || mem_dout !== 8'd0) begin
            bad++; $display("FAIL reset_mem: got a=%h d=%h expected 0", mem_a, mem_dout);
        end
        total++;
        if (if_data !== 32'd0 || ls_rdata !== 32'd0) begin
            bad++; $display("FAIL reset_data: got %h/%h expected 0", if_data, ls_rdata);
        end
        do_reset();
    endtask

    task automatic test_fetch();
        if_addr = 32'h100; if_valid = 1'b1;
        if_q.push_back('{1'b1, 32'h0000_0513});
        for (int j = 0; j < 4; j++) begin
            @(negedge clk_in);
            total++;
            if (mem_a !== 32'(32'h100 + j) || mem_wr !== 1'b0) begin
                bad++; $display("FAIL fetch_addr: got a=%h wr=%b expected a=%h wr=0",
                                mem_a, mem_wr, 32'h100 + j);
            end
        end
        @(negedge clk_in);
        total++;
        if (if_ready !== 1'b0) begin
            bad++; $display("FAIL fetch_early: got if_ready=%b expected 0", if_ready);
        end
        @(negedge clk_in);
        total++;
        if (if_ready !== 1'b1) begin
            bad++; $display("FAIL fetch_latency: got if_ready=%b expected 1", if_ready);
        end
        @(negedge clk_in);
        total++;
        if (if_ready !== 1'b0 || mem_a !== 32'h103) begin
            bad++; $display("FAIL fetch_bubble: got rdy=%b a=%h expected rdy=0 a=103",
                            if_ready, mem_a);
        end
        if_valid = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_store();
        ls_wr = 1'b1; ls_size = 2'd1; ls_addr = 32'h200; ls_wdata = 32'h1234; ls_valid = 1'b1;
        wr_q.push_back('{32'h200, 8'h34});
        wr_q.push_back('{32'h201, 8'h12});
        ls_q.push_back('{1'b0, 32'h0});
        for (int j = 0; j < 2; j++) begin
            @(negedge clk_in);
            total++;
            if (mem_wr !== 1'b1 || ls_ready !== 1'b0) begin
                bad++; $display("FAIL store_wr: got wr=%b rdy=%b expected wr=1 rdy=0",
                                mem_wr, ls_ready);
            end
        end
        @(negedge clk_in);
        total++;
        if ({mem_wr, ls_ready} !== 2'b01) begin
            bad++; $display("FAIL store_done: got wr,rdy=%b expected 01", {mem_wr, ls_ready});
        end
        ls_valid = 1'b0;
        @(negedge clk_in);
        total++;
        if (ls_ready !== 1'b0) begin
            bad++; $display("FAIL store_pulse: got ls_ready=%b expected 0", ls_ready);
        end
    endtask

    task automatic test_loads();
        int cyc;
        int n;
        logic [31:0] exp_d;
        for (int sz = 0; sz < 4; sz++) begin
            n     = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
            exp_d = (sz == 0) ? 32'h11 : (sz == 1) ? 32'h2211 : 32'h4433_2211;
            ls_wr = 1'b0; ls_size = 2'(sz); ls_addr = 32'h20; ls_valid = 1'b1;
            ls_q.push_back('{1'b1, exp_d});
            cyc = 0;
            do begin
                @(negedge clk_in);
                cyc++;
            end while (!ls_ready && cyc < 10);
            total++;
            if (ls_ready !== 1'b1 || cyc != n + 2) begin
                bad++; $display("FAIL load_latency: size=%0d got cyc=%0d rdy=%b expected cyc=%0d",
                                sz, cyc, ls_ready, n + 2);
            end
            ls_valid = 1'b0;
            @(negedge clk_in);
        end
        // Address increment wraps across the top of the address space.
        if_addr = 32'hFFFF_FFFE; if_valid = 1'b1;
        if_q.push_back('{1'b1, 32'hDDCC_BBAA});
        for (int j = 0; j < 4; j++) begin
            @(negedge clk_in);
            total++;
            if (mem_a !== 32'(32'hFFFF_FFFE + j)) begin
                bad++; $display("FAIL wrap_addr: got %h expected %h", mem_a, 32'hFFFF_FFFE + j);
            end
        end
        repeat (2) @(negedge clk_in);
        total++;
        if (if_ready !== 1'b1) begin
            bad++; $display("FAIL wrap_done: got if_ready=%b expected 1", if_ready);
        end
        if_valid = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_rdy();
        rdy_in = 1'b0; if_addr = 32'h100; if_valid = 1'b1;
        if_q.push_back('{1'b1, 32'h0000_0513});
        repeat (4) begin
            @(negedge clk_in);
            total++;
            if (if_ready !== 1'b0 || mem_a !== 32'h1) begin
                bad++; $display("FAIL rdy_block: got rdy=%b a=%h expected rdy=0 a=1",
                                if_ready, mem_a);
            end
        end
        rdy_in = 1'b1;
        repeat (6) @(negedge clk_in);
        total++;
        if (if_ready !== 1'b1) begin
            bad++; $display("FAIL rdy_resume: got if_ready=%b expected 1", if_ready);
        end
        if_valid = 1'b0;
        @(negedge clk_in);
    endtask

    // Assert a fetch and a 1-byte load together; want_ls selects the expected first grant.
    task automatic run_both(input logic [31:0] ld_addr, input logic [31:0] ld_data,
                            input logic want_ls);
        logic if_done, ls_done;
        int   first;
        if_addr = 32'h100; if_valid = 1'b1;
        ls_wr = 1'b0; ls_size = 2'd0; ls_addr = ld_addr; ls_valid = 1'b1;
        if_q.push_back('{1'b1, 32'h0000_0513});
        ls_q.push_back('{1'b1, ld_data});
        if_done = 1'b0; ls_done = 1'b0; first = 0;
        @(negedge clk_in);
        total++;
        if (mem_a !== (want_ls ? ld_addr : 32'h100)) begin
            bad++; $display("FAIL cont_grant: got a=%h expected %h", mem_a,
                            want_ls ? ld_addr : 32'h100);
        end
        for (int j = 0; j < 20 && !(if_done && ls_done); j++) begin
            @(negedge clk_in);
            if (ls_ready) begin ls_valid = 1'b0; ls_done = 1'b1; if (first == 0) first = 2; end
            if (if_ready) begin if_valid = 1'b0; if_done = 1'b1; if (first == 0) first = 1; end
        end
        total++;
        if (!(if_done && ls_done) || first != (want_ls ? 2 : 1)) begin
            bad++; $display("FAIL cont_order: got first=%0d done=%b%b expected first=%0d",
                            first, if_done, ls_done, want_ls ? 2 : 1);
        end
        if_valid = 1'b0; ls_valid = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_contention();
        int cyc;
        do_reset();
        run_both(32'h10, 32'hA5, 1'b1);
        run_both(32'h10, 32'hA5, 1'b1);
        ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h11; ls_valid = 1'b1;
        ls_q.push_back('{1'b1, 32'h5A});
        cyc = 0;
        do begin @(negedge clk_in); cyc++; end while (!ls_ready && cyc < 10);
        total++;
        if (ls_ready !== 1'b1) begin
            bad++; $display("FAIL cont_lone: got ls_ready=%b expected 1", ls_ready);
        end
        ls_valid = 1'b0;
        @(negedge clk_in);
        run_both(32'h10, 32'hA5, 1'b0);
    endtask

    task automatic test_rob_clear();
        int cyc;
        if_addr = 32'h100; if_valid = 1'b1;
        repeat (2) @(negedge clk_in);
        @(negedge clk_in);
        rob_clear = 1'b1;
        @(negedge clk_in);
        rob_clear = 1'b0; if_valid = 1'b0;
        repeat (4) begin
            total++;
            if (if_ready !== 1'b0) begin
                bad++; $display("FAIL clr_fetch: got if_ready=%b expected 0", if_ready);
            end
            @(negedge clk_in);
        end
        if_addr = 32'h400; if_valid = 1'b1;
        if_q.push_back('{1'b1, 32'hDEAD_BEEF});
        @(negedge clk_in);
        total++;
        if (mem_a !== 32'h400) begin
            bad++; $display("FAIL clr_regrant: got a=%h expected 400", mem_a);
        end
        repeat (5) @(negedge clk_in);
        total++;
        if (if_ready !== 1'b1) begin
            bad++; $display("FAIL clr_refetch: got if_ready=%b expected 1", if_ready);
        end
        if_valid = 1'b0;
        @(negedge clk_in);
        ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h204; ls_wdata = 32'hCAFE_F00D; ls_valid = 1'b1;
        wr_q.push_back('{32'h204, 8'h0D});
        wr_q.push_back('{32'h205, 8'hF0});
        wr_q.push_back('{32'h206, 8'hFE});
        wr_q.push_back('{32'h207, 8'hCA});
        ls_q.push_back('{1'b0, 32'h0});
        cyc = 0;
        do begin
            @(negedge clk_in);
            cyc++;
            rob_clear = (cyc == 3);
        end while (!ls_ready && cyc < 10);
        rob_clear = 1'b0;
        total++;
        if (ls_ready !== 1'b1 || cyc != 5) begin
            bad++; $display("FAIL clr_store: got rdy=%b cyc=%0d expected rdy=1 cyc=5",
                            ls_ready, cyc);
        end
        ls_valid = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_io_backpressure();
        io_buffer_full = 1'b1;
        if_addr = 32'h100; if_valid = 1'b1;
        ls_wr = 1'b1; ls_size = 2'd0; ls_addr = 32'h30000; ls_wdata = 32'h5A; ls_valid = 1'b1;
        if_q.push_back('{1'b1, 32'h0000_0513});
        wr_q.push_back('{32'h30000, 8'h5A});
        ls_q.push_back('{1'b0, 32'h0});
        @(negedge clk_in);
        total++;
        if (mem_a !== 32'h100 || mem_wr !== 1'b0) begin
            bad++; $display("FAIL io_fetch_first: got a=%h wr=%b expected a=100 wr=0",
                            mem_a, mem_wr);
        end
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk_in);
            if (if_ready) if_valid = 1'b0;
            total++;
            if (mem_wr !== 1'b0) begin
                bad++; $display("FAIL io_hold: cycle %0d got mem_wr=%b expected 0", j, mem_wr);
            end
        end
        io_buffer_full = 1'b0;
        @(negedge clk_in);
        total++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h30000) begin
            bad++; $display("FAIL io_release: got wr=%b a=%h expected wr=1 a=30000", mem_wr, mem_a);
        end
        @(negedge clk_in);
        total++;
        if (ls_ready !== 1'b1) begin
            bad++; $display("FAIL io_done: got ls_ready=%b expected 1", ls_ready);
        end
        ls_valid = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_async_reset();
        logic seen;
        ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h300; ls_wdata = 32'h1122_3344; ls_valid = 1'b1;
        wr_q.push_back('{32'h300, 8'h44});
        wr_q.push_back('{32'h301, 8'h33});
        repeat (2) @(negedge clk_in);
        #2 rst_in = 1'b0;
        #1;
        total++;
        if (mem_wr !== 1'b0 || ls_ready !== 1'b0) begin
            bad++; $display("FAIL async_rst: got wr=%b rdy=%b expected 0 0", mem_wr, ls_ready);
        end
        ls_valid = 1'b0;
        @(negedge clk_in);
        #1 rst_in = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk_in);
            if (ls_ready || mem_wr) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL async_after: got activity=%b expected 0", seen);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
        ram[12'h020] = 8'h11; ram[12'h021] = 8'h22; ram[12'h022] = 8'h33; ram[12'h023] = 8'h44;
        ram[12'hFFE] = 8'hAA; ram[12'hFFF] = 8'hBB; ram[12'h000] = 8'hCC; ram[12'h001] = 8'hDD;
        ram[12'h400] = 8'hEF; ram[12'h401] = 8'hBE; ram[12'h402] = 8'hAD; ram[12'h403] = 8'hDE;
        ram[12'h010] = 8'hA5; ram[12'h011] = 8'h5A;
        test_reset();
        test_fetch();
        test_store();
        test_loads();
        test_rdy();
        test_contention();
        test_rob_clear();
        test_io_backpressure();
        test_async_reset();
        total++;
        if (if_q.size() + ls_q.size() + wr_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_left: got %0d/%0d/%0d pending expected 0",
                            if_q.size(), ls_q.size(), wr_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
